// File: rtl/crc24_append_core.sv
// Bit-serial BLE CRC24 generator: forwards PDU bits unchanged, then appends the
// 24-bit CRC (MSB first) on the same stream feeding the whitening stage.
module crc24_append_core #(
   parameter int                   CRC_WIDTH     = 24,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY_MASK = 24'h00065B
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CRC_WIDTH-1:0] crc_init,
   input  logic                 crc_init_load,
   input  logic                 data_in,
   input  logic                 data_in_valid,
   input  logic                 data_in_last,
   output logic                 in_ready,
   output logic                 data_out,
   output logic                 data_out_valid,
   output logic                 data_out_last
);

   typedef enum logic {
      ST_ACCEPT  = 1'b0,
      ST_CRC_OUT = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [CRC_WIDTH-1:0] lfsr_q, lfsr_d;
   logic [4:0]           cnt_q, cnt_d;
   logic                 dataOut_q, dataOut_d;
   logic                 dataOutValid_q, dataOutValid_d;
   logic                 dataOutLast_q, dataOutLast_d;
   logic                 feedback;

   assign in_ready       = (state_q == ST_ACCEPT);
   assign data_out       = dataOut_q;
   assign data_out_valid = dataOutValid_q;
   assign data_out_last  = dataOutLast_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_ACCEPT;
         lfsr_q         <= crc_init;
         cnt_q          <= '0;
         dataOut_q      <= 1'b0;
         dataOutValid_q <= 1'b0;
         dataOutLast_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         lfsr_q         <= lfsr_d;
         cnt_q          <= cnt_d;
         dataOut_q      <= dataOut_d;
         dataOutValid_q <= dataOutValid_d;
         dataOutLast_q  <= dataOutLast_d;
      end
   end

   // Preset wins over everything, including an in-progress CRC emission.
   always_comb begin
      state_d        = state_q;
      lfsr_d         = lfsr_q;
      cnt_d          = cnt_q;
      dataOut_d      = dataOut_q;
      dataOutValid_d = 1'b0;
      dataOutLast_d  = 1'b0;
      feedback       = lfsr_q[CRC_WIDTH-1] ^ data_in;

      if (crc_init_load) begin
         lfsr_d  = crc_init;
         state_d = ST_ACCEPT;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (data_in_valid) begin
                  lfsr_d         = {lfsr_q[CRC_WIDTH-2:0], 1'b0} ^
                                   (feedback ? CRC_POLY_MASK : '0);
                  dataOut_d      = data_in;
                  dataOutValid_d = 1'b1;
                  if (data_in_last) begin
                     state_d = ST_CRC_OUT;
                     cnt_d   = '0;
                  end
               end
            end
            ST_CRC_OUT: begin
               dataOut_d      = lfsr_q[CRC_WIDTH-1];
               dataOutValid_d = 1'b1;
               lfsr_d         = {lfsr_q[CRC_WIDTH-2:0], 1'b0};
               if (cnt_q == 5'd23) begin
                  dataOutLast_d = 1'b1;
                  state_d       = ST_ACCEPT;
                  cnt_d         = '0;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
            default: begin
               state_d = ST_ACCEPT;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc24_append_core.sv
// Directed bench for crc24_append_core: hand-computed CRCs for single-bit packets
// plus a reference CRC24 model for a gapped multi-bit packet.
module tb_crc24_append_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] crc_init = 24'h0;
   logic        crc_init_load = 1'b0;
   logic        data_in = 1'b0;
   logic        data_in_valid = 1'b0;
   logic        data_in_last = 1'b0;
   logic        in_ready;
   logic        data_out;
   logic        data_out_valid;
   logic        data_out_last;

   int errorCount = 0;
   int checkCount = 0;

   crc24_append_core dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .crc_init      (crc_init),
      .crc_init_load (crc_init_load),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_last  (data_in_last),
      .in_ready      (in_ready),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .data_out_last (data_out_last)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference CRC24: same LFSR recurrence as the air protocol defines.
   function automatic logic [23:0] crcModel(input logic [23:0] init,
                                            input logic [23:0] bits, input int n);
      logic [23:0] l = init;
      logic        fb;
      for (int k = 0; k < n; k++) begin
         fb = l[23] ^ bits[k];
         l  = {l[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
      end
      return l;
   endfunction

   task automatic loadInit(input logic [23:0] init);
      crc_init      = init;
      crc_init_load = 1'b1;
      tick();
      crc_init_load = 1'b0;
      checkOutput("loadValid", 32'(data_out_valid), 32'd0);
      checkOutput("loadReady", 32'(in_ready), 32'd1);
   endtask

   // Drive one PDU bit and check it appears one cycle later.
   task automatic applyStimulus(input logic b, input logic last);
      data_in       = b;
      data_in_valid = 1'b1;
      data_in_last  = last;
      tick();
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      checkOutput("pduValid", 32'(data_out_valid), 32'd1);
      checkOutput("pduData", 32'(data_out), 32'(b));
      checkOutput("pduLast", 32'(data_out_last), 32'd0);
      checkOutput("pduReady", 32'(in_ready), last ? 32'd0 : 32'd1);
   endtask

   task automatic gapCycle();
      data_in_valid = 1'b0;
      tick();
      checkOutput("gapValid", 32'(data_out_valid), 32'd0);
      checkOutput("gapLast", 32'(data_out_last), 32'd0);
      checkOutput("gapReady", 32'(in_ready), 32'd1);
   endtask

   // Check the first nBits appended CRC bits; a full run also checks the tail.
   task automatic checkCrc(input logic [23:0] expCrc, input int nBits, input logic driveJunk);
      int lowCycles = 1;
      for (int i = 0; i < nBits; i++) begin
         if (driveJunk) begin
            data_in       = 1'($urandom_range(0, 1));
            data_in_last  = 1'($urandom_range(0, 1));
            data_in_valid = 1'b1;
         end
         tick();
         checkOutput($sformatf("crcValid[%0d]", i), 32'(data_out_valid), 32'd1);
         checkOutput($sformatf("crcData[%0d]", i), 32'(data_out), 32'(expCrc[23-i]));
         checkOutput($sformatf("crcLast[%0d]", i), 32'(data_out_last), 32'(i == 23));
         checkOutput($sformatf("crcReady[%0d]", i), 32'(in_ready), 32'(i == 23));
         if (!in_ready) lowCycles++;
      end
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      if (nBits == 24) begin
         checkOutput("readyLowCycles", 32'(lowCycles), 32'd24);
         tick();
         checkOutput("postValid", 32'(data_out_valid), 32'd0);
         checkOutput("postLast", 32'(data_out_last), 32'd0);
      end
   endtask

   initial begin
      logic [23:0] pdu;
      logic [23:0] expCrc;

      // Reset state
      tick();
      tick();
      checkOutput("resetValid", 32'(data_out_valid), 32'd0);
      checkOutput("resetLast", 32'(data_out_last), 32'd0);
      checkOutput("resetData", 32'(data_out), 32'd0);
      checkOutput("resetReady", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      $display("[TB] single 1 bit from zero preset");
      loadInit(24'h000000);
      applyStimulus(1'b1, 1'b1);
      checkCrc(24'h00065B, 24, 1'b0);

      $display("[TB] LFSR left at zero, packet without reload");
      applyStimulus(1'b0, 1'b1);
      checkCrc(24'h000000, 24, 1'b0);

      $display("[TB] plain shift from preset 0x000001");
      loadInit(24'h000001);
      applyStimulus(1'b0, 1'b1);
      checkCrc(24'h000002, 24, 1'b0);

      $display("[TB] feedback from MSB with preset 0x800000");
      loadInit(24'h800000);
      applyStimulus(1'b0, 1'b1);
      checkCrc(24'h00065B, 24, 1'b0);

      $display("[TB] gapped header+payload against model");
      pdu    = {8'hA5, 16'h2540};
      expCrc = crcModel(24'h555555, pdu, 24);
      loadInit(24'h555555);
      for (int k = 0; k < 24; k++) begin
         applyStimulus(pdu[k], k == 23);
         if (k == 3 || k == 17) gapCycle();
         if (k == 10) begin
            gapCycle();
            gapCycle();
         end
      end
      checkCrc(expCrc, 24, 1'b1);

      $display("[TB] preset abort during CRC emission");
      loadInit(24'h000000);
      applyStimulus(1'b1, 1'b1);
      checkCrc(24'h00065B, 10, 1'b0);
      crc_init      = 24'h000001;
      crc_init_load = 1'b1;
      data_in       = 1'b1;
      data_in_valid = 1'b1;
      tick();
      crc_init_load = 1'b0;
      data_in_valid = 1'b0;
      checkOutput("abortValid", 32'(data_out_valid), 32'd0);
      checkOutput("abortLast", 32'(data_out_last), 32'd0);
      checkOutput("abortReady", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) gapCycle();
      applyStimulus(1'b0, 1'b1);
      checkCrc(24'h000002, 24, 1'b0);

      $display("[TB] reset mid-PDU");
      loadInit(24'h123456);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      crc_init      = 24'h000000;
      rst_n         = 1'b0;
      data_in       = 1'b1;
      data_in_valid = 1'b1;
      tick();
      checkOutput("rstValid", 32'(data_out_valid), 32'd0);
      checkOutput("rstData", 32'(data_out), 32'd0);
      checkOutput("rstLast", 32'(data_out_last), 32'd0);
      checkOutput("rstReady", 32'(in_ready), 32'd1);
      rst_n         = 1'b1;
      data_in_valid = 1'b0;
      applyStimulus(1'b1, 1'b1);
      checkCrc(24'h00065B, 24, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
